// File: rtl/chip8_memory.sv
// CHIP-8 4 KiB memory responder: font preload, program byte loader, then CPU port.
// Optional macro CHIP8_MEM_WRPROT_EN protects addresses below PROG_BASE in RUN.
module chip8_memory #(
   parameter logic [11:0] FONT_BASE     = 12'h050,
   parameter logic [11:0] PROG_BASE     = 12'h200,
   parameter bit          WE_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] address_in,
   input  logic [7:0]  data_in,
   input  logic        write_enable,
   output logic [7:0]  data_out,
   input  logic        load_valid,
   input  logic [7:0]  load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        load_overflow,
   output logic        mem_ready
`ifdef CHIP8_MEM_WRPROT_EN
   ,
   output logic        wp_violation
`endif
);

   typedef enum logic [1:0] {S_FONT, S_LOAD, S_RUN} state_t;

   localparam logic [7:0] FONT [80] = '{
      8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
      8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
      8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
      8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
      8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
      8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
      8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
      8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
      8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
      8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
      8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
      8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
      8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
      8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
      8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
      8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
   };

   state_t      state, state_next;
   logic [6:0]  font_idx, font_idx_next;
   logic [11:0] count, count_next;
   logic        ovf_next;
   logic [11:0] prog_addr;
   logic        cpu_we;
   logic        ram_we;
   logic [11:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  mem [4096];

`ifdef CHIP8_MEM_WRPROT_EN
   logic        wp_next;
`endif

   assign prog_addr  = PROG_BASE + count;
   assign cpu_we     = WE_ACTIVE_LOW ? ~write_enable : write_enable;
   assign load_ready = (state == S_LOAD);
   assign mem_ready  = (state == S_RUN);

   always_comb begin
      state_next    = state;
      font_idx_next = font_idx;
      count_next    = count;
      ovf_next      = load_overflow;
      ram_we        = 1'b0;
      ram_addr      = address_in;
      ram_wdata     = data_in;
`ifdef CHIP8_MEM_WRPROT_EN
      wp_next       = wp_violation;
`endif
      unique case (state)
         S_FONT: begin
            ram_we    = 1'b1;
            ram_addr  = FONT_BASE + {5'd0, font_idx};
            ram_wdata = FONT[font_idx];
            if (font_idx == 7'd79) begin
               state_next    = S_LOAD;
               font_idx_next = 7'd0;
            end else begin
               font_idx_next = font_idx + 7'd1;
            end
         end
         S_LOAD: begin
            ram_addr  = prog_addr;
            ram_wdata = load_data;
            if (load_valid) begin
               ram_we     = 1'b1;
               count_next = count + 12'd1;
               // Top of RAM ends the load even without load_last
               if (prog_addr == 12'hFFF) begin
                  ovf_next   = 1'b1;
                  state_next = S_RUN;
               end else if (load_last) begin
                  state_next = S_RUN;
               end
            end
         end
         S_RUN: begin
            ram_we = cpu_we;
`ifdef CHIP8_MEM_WRPROT_EN
            if (cpu_we && (address_in < PROG_BASE)) begin
               ram_we  = 1'b0;
               wp_next = 1'b1;
            end
`endif
         end
         default: state_next = S_FONT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_FONT;
         font_idx      <= 7'd0;
         count         <= 12'd0;
         load_overflow <= 1'b0;
      end else begin
         state         <= state_next;
         font_idx      <= font_idx_next;
         count         <= count_next;
         load_overflow <= ovf_next;
      end
   end

`ifdef CHIP8_MEM_WRPROT_EN
   always_ff @(posedge clk) begin
      if (reset) wp_violation <= 1'b0;
      else       wp_violation <= wp_next;
   end
`endif

   always_ff @(posedge clk) begin
      if (ram_we && !reset) mem[ram_addr] <= ram_wdata;
   end

   // Read-first: the read sees the byte before this cycle's write
   always_ff @(posedge clk) begin
      if (reset)               data_out <= 8'h00;
      else if (state == S_RUN) data_out <= mem[ram_addr];
      else                     data_out <= 8'h00;
   end

endmodule

// File: tb/tb_chip8_memory.sv
// Directed bench for chip8_memory: font preload, loader, CPU port, reset, overflow.
module tb_chip8_memory;

   logic        clk;
   logic        reset;
   logic [11:0] address_in;
   logic [7:0]  data_in;
   logic        write_enable;
   logic [7:0]  data_out;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_last;
   logic        load_ready;
   logic        load_overflow;
   logic        mem_ready;
`ifdef CHIP8_MEM_WRPROT_EN
   logic        wp_violation;
`endif

   int tests = 0;
   int fails = 0;

   chip8_memory dut (
      .clk(clk),
      .reset(reset),
      .address_in(address_in),
      .data_in(data_in),
      .write_enable(write_enable),
      .data_out(data_out),
      .load_valid(load_valid),
      .load_data(load_data),
      .load_last(load_last),
      .load_ready(load_ready),
      .load_overflow(load_overflow),
      .mem_ready(mem_ready)
`ifdef CHIP8_MEM_WRPROT_EN
      ,
      .wp_violation(wp_violation)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] addr;
      logic        wr;
      logic [7:0]  wdata;
      logic        chk;
      logic [7:0]  exp;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [11:0] act,
                        input logic [11:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset        = 1'b1;
      load_valid   = 1'b0;
      load_last    = 1'b0;
      write_enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check({tag, "_rst_dout"}, {4'd0, data_out}, 12'h000);
      check({tag, "_rst_lrdy"}, {11'd0, load_ready}, 12'h000);
      check({tag, "_rst_mrdy"}, {11'd0, mem_ready}, 12'h000);
      check({tag, "_rst_ovf"}, {11'd0, load_overflow}, 12'h000);
      reset = 1'b0;
   endtask

   task automatic wait_font(input string tag);
      repeat (79) @(negedge clk);
      check({tag, "_lrdy_c79"}, {11'd0, load_ready}, 12'h000);
      check({tag, "_mrdy_c79"}, {11'd0, mem_ready}, 12'h000);
      @(negedge clk);
      check({tag, "_lrdy_c80"}, {11'd0, load_ready}, 12'h001);
   endtask

   task automatic rd(input logic [11:0] a, input logic [7:0] e,
                     input string name);
      address_in   = a;
      write_enable = 1'b1;
      @(negedge clk);
      check(name, {4'd0, data_out}, {4'd0, e});
   endtask

   task automatic push(input logic [7:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   initial begin
      logic [7:0] exp60;
      logic [7:0] sd;
`ifdef CHIP8_MEM_WRPROT_EN
      exp60 = 8'h10;
`else
      exp60 = 8'h77;
`endif
      vecs[0]  = '{12'h050, 1'b0, 8'h00, 1'b1, 8'hF0};
      vecs[1]  = '{12'h051, 1'b0, 8'h00, 1'b1, 8'h90};
      vecs[2]  = '{12'h09F, 1'b0, 8'h00, 1'b1, 8'h80};
      vecs[3]  = '{12'h05A, 1'b0, 8'h00, 1'b1, 8'hF0};
      vecs[4]  = '{12'h05B, 1'b0, 8'h00, 1'b1, 8'h10};
      vecs[5]  = '{12'h200, 1'b0, 8'h00, 1'b1, 8'h12};
      vecs[6]  = '{12'h201, 1'b0, 8'h00, 1'b1, 8'h34};
      vecs[7]  = '{12'h202, 1'b0, 8'h00, 1'b1, 8'h56};
      vecs[8]  = '{12'h300, 1'b1, 8'hAB, 1'b0, 8'h00};
      vecs[9]  = '{12'h300, 1'b0, 8'h00, 1'b1, 8'hAB};
      vecs[10] = '{12'h300, 1'b1, 8'hCD, 1'b1, 8'hAB};
      vecs[11] = '{12'h300, 1'b0, 8'h00, 1'b1, 8'hCD};
      vecs[12] = '{12'h060, 1'b1, 8'h77, 1'b1, 8'h10};
      vecs[13] = '{12'h060, 1'b0, 8'h00, 1'b1, exp60};

      reset        = 1'b1;
      address_in   = 12'h000;
      data_in      = 8'h00;
      write_enable = 1'b1;
      load_valid   = 1'b0;
      load_data    = 8'h00;
      load_last    = 1'b0;

      // Font preload timing, then a gapped load while the CPU tries to write
      do_reset("t1");
      wait_font("t1");
      address_in   = 12'h050;
      data_in      = 8'h00;
      write_enable = 1'b0;
      push(8'h12, 1'b0);
      @(negedge clk);
      check("t2_dout_load", {4'd0, data_out}, 12'h000);
      @(negedge clk);
      push(8'h34, 1'b0);
      write_enable = 1'b1;
      check("t2_mrdy_pre", {11'd0, mem_ready}, 12'h000);
      push(8'h56, 1'b1);
      check("t2_mrdy_post", {11'd0, mem_ready}, 12'h001);
      check("t2_lrdy_post", {11'd0, load_ready}, 12'h000);
      check("t2_ovf", {11'd0, load_overflow}, 12'h000);

`ifdef CHIP8_MEM_WRPROT_EN
      check("wp_pre", {11'd0, wp_violation}, 12'h000);
`endif
      for (int i = 0; i < 14; i++) begin
         address_in   = vecs[i].addr;
         data_in      = vecs[i].wdata;
         write_enable = vecs[i].wr ? 1'b0 : 1'b1;
         @(negedge clk);
         if (vecs[i].chk)
            check($sformatf("vec%0d", i), {4'd0, data_out},
                  {4'd0, vecs[i].exp});
      end
      write_enable = 1'b1;
`ifdef CHIP8_MEM_WRPROT_EN
      check("wp_post", {11'd0, wp_violation}, 12'h001);
`endif

      // Reset in the middle of a load
      do_reset("t4a");
      wait_font("t4a");
      for (int i = 0; i < 100; i++) begin
         push(8'(i + 1), 1'b0);
      end
      check("t4_mrdy_mid", {11'd0, mem_ready}, 12'h000);
      do_reset("t4b");
      wait_font("t4b");
      push(8'hA5, 1'b1);
      check("t4_mrdy", {11'd0, mem_ready}, 12'h001);
      rd(12'h200, 8'hA5, "t4_200");
      rd(12'h201, 8'h02, "t4_201");
      rd(12'h263, 8'h64, "t4_263");
      rd(12'h060, 8'h10, "t4_font060");

      // Full-length stream ending at the top of RAM
      do_reset("t5");
      wait_font("t5");
      for (int i = 0; i < 3584; i++) begin
         if (i == 0)         sd = 8'h5A;
         else if (i == 3583) sd = 8'hEE;
         else                sd = 8'(i);
         if (i == 3583) begin
            check("t5_mrdy_pre", {11'd0, mem_ready}, 12'h000);
            check("t5_lrdy_pre", {11'd0, load_ready}, 12'h001);
         end
         push(sd, 1'b0);
      end
      check("t5_ovf", {11'd0, load_overflow}, 12'h001);
      check("t5_mrdy", {11'd0, mem_ready}, 12'h001);
      check("t5_lrdy", {11'd0, load_ready}, 12'h000);
      load_valid = 1'b1;
      load_data  = 8'h99;
      repeat (3) @(negedge clk);
      load_valid = 1'b0;
      rd(12'hFFF, 8'hEE, "t5_FFF");
      rd(12'h200, 8'h5A, "t5_200");
      rd(12'h345, 8'h45, "t5_345");
      check("t5_ovf_hold", {11'd0, load_overflow}, 12'h001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
